// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 scancode decoder: FSM states,
// prefix bytes, discard/fake-shift classification and the key event record.
package ps2_kbd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE_E0,
        ST_PRE_F0,
        ST_PRE_E0F0,
        ST_SKIP_E1
    } decState_e;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam logic [7:0] PS2_PAUSE      = 8'hE1;
    localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;
    localparam logic [7:0] FAKE_SHIFT_L   = 8'h12;
    localparam logic [7:0] FAKE_SHIFT_R   = 8'h59;

    // Bytes still owed to the E1 Pause sequence after the E1 itself.
    localparam int PAUSE_SKIP = 7;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } kbdEvent_t;

    // Controller responses and error codes that never describe a key.
    function automatic logic isDiscard(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: isDiscard = 1'b1;
            default:                    isDiscard = 1'b0;
        endcase
    endfunction

    function automatic logic isFakeShift(input logic [7:0] b);
        isFakeShift = (b == FAKE_SHIFT_L) || (b == FAKE_SHIFT_R);
    endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Byte-in / key-event-out bundle of the scancode decoder.
// The slave modport is the decoder's view, master is the surrounding system.
interface ps2_scancode_decoder_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [7:0]       key_code;
    logic             key_ext;
    logic             key_release;
    logic             key_valid;
    logic             key_ready;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;

    modport master (
        output rx_data, rx_valid, key_ready,
        input  key_code, key_ext, key_release, key_valid, fifo_count, overflow
    );

    modport slave (
        input  rx_data, rx_valid, key_ready,
        output key_code, key_ext, key_release, key_valid, fifo_count, overflow
    );

endinterface

// File: rtl/kbd_event_fifo.sv
// Show-ahead synchronous FIFO of key events; the head is held after the
// FIFO drains so consumers never see stale memory contents.
module kbd_event_fifo
    import ps2_kbd_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  kbdEvent_t        pushData_i,
    input  logic             pop_i,
    output kbdEvent_t        head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    kbdEvent_t        mem_q [DEPTH];
    kbdEvent_t        last_q;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush, doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign doPop   = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign doPush  = push_i && (!full_o || doPop);

    always_comb begin
        wrPtr_d = doPush ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d = doPop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + CNT_W'(1);
        end else if (doPop && !doPush) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= '0;
        end else if (!empty_o) begin
            last_q <= mem_q[rdPtr_q];
        end
    end

    assign head_o  = empty_o ? last_q : mem_q[rdPtr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 decoder: strips E0/F0/E1 prefixes and queues key events.
// Build with PS2_REPEAT_FILTER_EN to drop typematic repeats of the held key.
module ps2_scancode_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic                  CLK,
    input  logic                  reset,
    ps2_scancode_decoder_if.slave kbd
);

    localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam int                 CNT_W      = $clog2(FIFO_DEPTH) + 1;

    decState_e          state_q, state_d;
    logic [2:0]         skipCnt_q, skipCnt_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               overflow_q, overflow_d;
    logic               timedOut;
    logic               rawPush;
    kbdEvent_t          rawEvent;
    logic               fifoPush;
    logic               fifoFull, fifoEmpty;
    logic [CNT_W-1:0]   fifoCount;
    kbdEvent_t          headEvent;

    // The idle timer only matters while a prefix sequence is half received.
    assign timedOut = (state_q != ST_IDLE) && (timer_q == TIMER_LAST);
    assign timer_d  = kbd.rx_valid ? '0 :
                      (timer_q == TIMER_LAST) ? timer_q : timer_q + TIMER_W'(1);

    always_comb begin
        state_d   = state_q;
        skipCnt_d = skipCnt_q;
        rawPush   = 1'b0;
        rawEvent  = '{code: kbd.rx_data, ext: 1'b0, rel: 1'b0};
        if (kbd.rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (kbd.rx_data == PS2_EXT) begin
                        state_d = ST_PRE_E0;
                    end else if (kbd.rx_data == PS2_BRK) begin
                        state_d = ST_PRE_F0;
                    end else if (kbd.rx_data == PS2_PAUSE) begin
                        state_d   = ST_SKIP_E1;
                        skipCnt_d = 3'(PAUSE_SKIP);
                    end else begin
                        rawPush = !isDiscard(kbd.rx_data);
                    end
                end
                ST_PRE_E0: begin
                    if (kbd.rx_data == PS2_BRK) begin
                        state_d = ST_PRE_E0F0;
                    end else begin
                        state_d      = ST_IDLE;
                        rawPush      = !isFakeShift(kbd.rx_data);
                        rawEvent.ext = 1'b1;
                    end
                end
                ST_PRE_F0: begin
                    state_d      = ST_IDLE;
                    rawPush      = 1'b1;
                    rawEvent.rel = 1'b1;
                end
                ST_PRE_E0F0: begin
                    state_d      = ST_IDLE;
                    rawPush      = !isFakeShift(kbd.rx_data);
                    rawEvent.ext = 1'b1;
                    rawEvent.rel = 1'b1;
                end
                ST_SKIP_E1: begin
                    // Pause has no break code, so the whole sequence becomes one make.
                    skipCnt_d = skipCnt_q - 3'd1;
                    if (skipCnt_q == 3'd1) begin
                        state_d  = ST_IDLE;
                        rawPush  = 1'b1;
                        rawEvent = '{code: PS2_PAUSE_CODE, ext: 1'b1, rel: 1'b0};
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (timedOut) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            skipCnt_q <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            skipCnt_q <= skipCnt_d;
            timer_q   <= timer_d;
        end
    end

`ifdef PS2_REPEAT_FILTER_EN
    logic [7:0] heldCode_q, heldCode_d;
    logic       heldExt_q, heldExt_d;
    logic       heldValid_q, heldValid_d;
    logic       heldMatch;

    assign heldMatch = heldValid_q && (heldCode_q == rawEvent.code)
                       && (heldExt_q == rawEvent.ext);

    always_comb begin
        heldCode_d  = heldCode_q;
        heldExt_d   = heldExt_q;
        heldValid_d = heldValid_q;
        fifoPush    = rawPush;
        if (rawPush) begin
            if (rawEvent.rel) begin
                if (heldMatch) begin
                    heldValid_d = 1'b0;
                end
            end else if (heldMatch) begin
                fifoPush = 1'b0;
            end else begin
                heldCode_d  = rawEvent.code;
                heldExt_d   = rawEvent.ext;
                heldValid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            heldCode_q  <= '0;
            heldExt_q   <= 1'b0;
            heldValid_q <= 1'b0;
        end else begin
            heldCode_q  <= heldCode_d;
            heldExt_q   <= heldExt_d;
            heldValid_q <= heldValid_d;
        end
    end
`else
    assign fifoPush = rawPush;
`endif

    // Sticky record that a key event was lost to a full FIFO.
    assign overflow_d = overflow_q
                        | (fifoPush && fifoFull && !(kbd.key_ready && !fifoEmpty));

    always_ff @(posedge CLK) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    kbd_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) eventFifo (
        .clk        (CLK),
        .reset      (reset),
        .push_i     (fifoPush),
        .pushData_i (rawEvent),
        .pop_i      (kbd.key_ready),
        .head_o     (headEvent),
        .count_o    (fifoCount),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    assign kbd.key_code    = headEvent.code;
    assign kbd.key_ext     = headEvent.ext;
    assign kbd.key_release = headEvent.rel;
    assign kbd.key_valid   = !fifoEmpty;
    assign kbd.fifo_count  = fifoCount;
    assign kbd.overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: a byte-sequence reference model
// fills an expected-event queue, a negedge monitor pops and compares.
module tb_ps2_scancode_decoder;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } keyEvent_t;

    logic clk = 1'b0;
    logic reset;

    ps2_scancode_decoder_if #(.FIFO_DEPTH(DEPTH)) bus ();

    ps2_scancode_decoder #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLK   (clk),
        .reset (reset),
        .kbd   (bus)
    );

    always #5 clk = ~clk;

    keyEvent_t  expQ [$];
    logic [7:0] pendBytes [$];
    int         rdIdx       = 0;
    logic       popPending  = 1'b0;
    logic       expOverflow = 1'b0;
    int         sinceByte   = 0;
    keyEvent_t  lastEv;
    int         checks      = 0;
    int         failures    = 0;
    int         readyMode   = 0;
    logic [7:0] noiseBytes [8] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
`ifdef PS2_REPEAT_FILTER_EN
    logic [7:0] heldCode  = 8'h00;
    logic       heldExt   = 1'b0;
    logic       heldValid = 1'b0;
`endif

    function automatic logic isNoise(input logic [7:0] b);
        isNoise = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (noiseBytes[i] == b) isNoise = 1'b1;
        end
    endfunction

    // Reference decoder: collects bytes until they form a whole key sequence.
    function automatic void decodeByte(input logic [7:0] b, output logic got,
                                       output keyEvent_t ev);
        int idx;
        got = 1'b0;
        ev  = '{8'h00, 1'b0, 1'b0};
        pendBytes.push_back(b);
        if (pendBytes[0] == 8'hE1) begin
            if (pendBytes.size() == 8) begin
                got = 1'b1;
                ev  = '{8'h77, 1'b1, 1'b0};
                pendBytes.delete();
            end
            return;
        end
        ev.ext = (pendBytes[0] == 8'hE0);
        idx    = ev.ext ? 1 : 0;
        if (pendBytes.size() > idx && pendBytes[idx] == 8'hF0) begin
            ev.rel = 1'b1;
            idx++;
        end
        if (pendBytes.size() <= idx) return;
        ev.code = pendBytes[idx];
        pendBytes.delete();
        if (!ev.ext && !ev.rel && isNoise(ev.code)) return;
        if (ev.ext && (ev.code == 8'h12 || ev.code == 8'h59)) return;
        got = 1'b1;
    endfunction

    function automatic void offerEvent(input keyEvent_t ev);
        int occ;
`ifdef PS2_REPEAT_FILTER_EN
        if (!ev.rel) begin
            if (heldValid && heldCode == ev.code && heldExt == ev.ext) return;
            heldCode  = ev.code;
            heldExt   = ev.ext;
            heldValid = 1'b1;
        end else if (heldValid && heldCode == ev.code && heldExt == ev.ext) begin
            heldValid = 1'b0;
        end
`endif
        occ = expQ.size() - rdIdx + (popPending ? 1 : 0);
        if (occ >= DEPTH && !popPending) expOverflow = 1'b1;
        else expQ.push_back(ev);
    endfunction

    // Model process: runs the reference on every byte the DUT samples.
    initial begin
        logic      got;
        keyEvent_t ev;
        forever begin
            @(posedge clk);
            if (reset) begin
                pendBytes.delete();
                sinceByte   = 0;
                expOverflow = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
                heldValid = 1'b0;
`endif
            end else if (bus.rx_valid) begin
                if (sinceByte >= TIMEOUT) pendBytes.delete();
                sinceByte = 0;
                decodeByte(bus.rx_data, got, ev);
                if (got) offerEvent(ev);
            end else if (sinceByte < 1000000) begin
                sinceByte++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    // Monitor: compares outputs each cycle and pops the head on a handshake.
    initial begin
        int        occ;
        keyEvent_t expHead;
        forever begin
            @(negedge clk);
            if (reset) begin
                rdIdx      = expQ.size();
                popPending = 1'b0;
                lastEv     = '{8'h00, 1'b0, 1'b0};
            end else begin
                occ = expQ.size() - rdIdx;
                if (occ != 0) expHead = expQ[rdIdx];
                else          expHead = lastEv;
                checkOutput("fifo_count",  32'(bus.fifo_count),  32'(occ));
                checkOutput("key_valid",   32'(bus.key_valid),   32'(occ != 0));
                checkOutput("overflow",    32'(bus.overflow),    32'(expOverflow));
                checkOutput("key_code",    32'(bus.key_code),    32'(expHead.code));
                checkOutput("key_ext",     32'(bus.key_ext),     32'(expHead.ext));
                checkOutput("key_release", 32'(bus.key_release), 32'(expHead.rel));
                if (bus.key_ready && occ != 0) begin
                    lastEv     = expHead;
                    rdIdx++;
                    popPending = 1'b1;
                end else begin
                    popPending = 1'b0;
                end
            end
        end
    end

    task automatic driveTick(input logic valid, input logic [7:0] data);
        @(posedge clk);
        #1;
        bus.rx_valid = valid;
        bus.rx_data  = data;
        if (readyMode == 2) bus.key_ready = 1'($urandom_range(0, 1));
        else                bus.key_ready = (readyMode == 1);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        driveTick(1'b1, b);
        repeat (gap) driveTick(1'b0, 8'h00);
    endtask

    task automatic applyReset();
        driveTick(1'b0, 8'h00);
        reset = 1'b1;
        repeat (2) driveTick(1'b0, 8'h00);
        reset = 1'b0;
    endtask

    function automatic logic [7:0] randomByte();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 3)       randomByte = 8'hE0;
        else if (r < 5)  randomByte = 8'hF0;
        else if (r == 5) randomByte = noiseBytes[$urandom_range(0, 7)];
        else if (r == 6) randomByte = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
        else if (r == 7) randomByte = 8'hE1;
        else             randomByte = 8'($urandom_range(1, 8'h83));
    endfunction

    initial begin
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.key_ready = 1'b0;
        repeat (3) driveTick(1'b0, 8'h00);
        reset = 1'b0;
        repeat (3) driveTick(1'b0, 8'h00);

        // Plain make, prefixed break, suppressed fake shift.
        readyMode = 1;
        applyStimulus(8'h1C, 4);
        applyStimulus(8'hE0, 0);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h75, 4);
        applyStimulus(8'hE0, 1);
        applyStimulus(8'h12, 4);

        // Abandoned E0 prefix after an idle gap longer than the timeout.
        applyStimulus(8'hE0, 100);
        applyStimulus(8'h1C, 4);

        // Fill the FIFO, overflow it, then push and pop together while full.
        readyMode = 0;
        for (int c = 8'h15; c <= 8'h1D; c++) applyStimulus(8'(c), 0);
        repeat (3) driveTick(1'b0, 8'h00);
        readyMode = 1;
        applyStimulus(8'h2A, 0);
        readyMode = 0;
        repeat (3) driveTick(1'b0, 8'h00);
        readyMode = 1;
        repeat (12) driveTick(1'b0, 8'h00);

        // Typematic repeat sequence.
        applyStimulus(8'h1C, 1);
        applyStimulus(8'h1C, 1);
        applyStimulus(8'h1C, 1);
        applyStimulus(8'hF0, 1);
        applyStimulus(8'h1C, 1);
        applyStimulus(8'h1C, 4);

        // Pause sequence.
        applyStimulus(8'hE1, 0);
        applyStimulus(8'h14, 0);
        applyStimulus(8'h77, 0);
        applyStimulus(8'hE1, 0);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h14, 0);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h77, 4);

        // Randomized traffic with changing backpressure.
        for (int i = 0; i < 1500; i++) begin
            if (i % 150 == 0) readyMode = int'($urandom_range(0, 2));
            applyStimulus(randomByte(),
                          ($urandom_range(0, 9) == 0) ? 80 : int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a prefix with events queued.
        readyMode = 0;
        applyStimulus(8'h21, 0);
        applyStimulus(8'h22, 0);
        applyStimulus(8'hE0, 0);
        applyReset();
        applyStimulus(8'h75, 3);
        readyMode = 1;
        repeat (30) driveTick(1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
Sits between the PS/2 receive controller and the keyboard input stage, on the 50 MHz processor clock. Turns the raw byte stream from the PS/2 controller into complete key events. Each event carries a code, an extended flag and a make/break flag. Events are buffered in a small FIFO so that the consumer can apply ready/valid backpressure without losing keystrokes.

Parameters:
- FIFO_DEPTH, 8: event FIFO entries; must be a power of two, 2..64.
- TIMEOUT_CYCLES, 2500000: idle cycles (50 ms at 50 MHz) after which a partial prefix sequence is abandoned.

Ports:
- CLK  in  1  system clock (50 MHz domain).
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from the PS/2 controller.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- key_code  out  8  scancode of the head event (set 2, prefixes stripped).
- key_ext  out  1  head event was E0-prefixed.
- key_release  out  1  head event is a break (F0-prefixed).
- key_valid  out  1  FIFO is non-empty.
- key_ready  in  1  consumer accepts the head event.
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy.
- overflow  out  1  sticky; set when an event was dropped because the FIFO was full.

Behaviour:
- Reset: state=IDLE; FIFO empty; key_valid=0; key_code=0; key_ext=0; key_release=0; fifo_count=0; overflow=0; timeout counter=0.
- Reset takes priority over everything, including mid-sequence bytes and a pending pop.
- Decoder FSM states: IDLE, PRE_E0, PRE_F0, PRE_E0F0, SKIP_E1. It advances only on cycles where rx_valid=1.
- In IDLE:
  - E0 -> PRE_E0.
  - F0 -> PRE_F0.
  - E1 -> SKIP_E1 with skip count=7.
  - 00, AA, EE, FA, FC, FD, FE, FF are discarded, stay IDLE.
  - Any other byte pushes {code, ext=0, rel=0}.
- In PRE_E0:
  - F0 -> PRE_E0F0.
  - 12 and 59 (fake-shift) are discarded -> IDLE.
  - Any other byte pushes {code, 1, 0} -> IDLE.
- PRE_F0: any byte pushes {code, 0, 1} -> IDLE.
- PRE_E0F0:
  - 12 and 59 are discarded -> IDLE.
  - Any other byte pushes {code, 1, 1} -> IDLE.
- SKIP_E1: each byte decrements the skip count; at 0 the block pushes {8'h77, 1, 0} (Pause, reported as a make only) -> IDLE.
- Timeout:
  - The counter clears on every rx_valid and otherwise increments, saturating.
  - In any non-IDLE state, reaching TIMEOUT_CYCLES-1 forces IDLE with no push.
- Latency: the final byte strobe in cycle N produces key_valid=1 and the new head visible in cycle N+1 if the FIFO was empty.
- FIFO:
  - Show-ahead: outputs reflect the head entry while key_valid=1.
  - When empty, outputs hold their last value.
  - A pop occurs when key_valid && key_ready.
- Full FIFO:
  - A push without a simultaneous pop is dropped and sets overflow; the FIFO contents are unchanged.
  - Push and pop together while full: both are performed; count stays at FIFO_DEPTH.
- Empty FIFO: key_ready is ignored. A push with key_ready=1 in the same cycle does not bypass the FIFO; the event is popped no earlier than N+1.
- Pointers wrap modulo FIFO_DEPTH.
- overflow clears only on reset.

Optional Feature:
- Macro: PS2_REPEAT_FILTER_EN.
- Defined:
  - The block holds a register {held_code, held_ext, held_valid}.
  - A make whose {code, ext} equals the held key while held_valid=1 is discarded as typematic repeat.
  - Any other make is pushed and becomes the held key.
  - A break matching the held key clears held_valid.
  - Breaks are always pushed.
  - Reset clears held_valid.
- Undefined: every make is pushed, including typematic repeats; the held-key register is absent.

Decomposition:
- Package ps2_kbd_pkg:
  - FSM state enum.
  - Prefix constants: PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1.
  - Discard-byte list.
  - Fake-shift codes 8'h12 and 8'h59.
  - Packed event struct {code[7:0], ext, rel}, 10 bits.
- Sub-module kbd_event_fifo: a synchronous FIFO of event structs with show-ahead output, count, and full/empty flags. The decoder FSM and timeout logic stay in the top.

Test Plan:
- Bytes 1C; pop with key_ready=1 -> one event {1C,0,0}; key_valid high exactly one cycle after the strobe.
- Bytes E0 F0 75 -> event {75,1,1}. Bytes E0 12 -> no event; fifo_count stays 0.
- Bytes E0, then 2,500,000 idle cycles, then 1C -> single event {1C,0,0}; no extended flag.
- key_ready=0 with 9 makes 15..1D (FIFO_DEPTH=8) -> fifo_count=8; overflow=1; pop order 15..1C; 1D is lost.
- Full FIFO with push and pop in the same cycle -> count stays 8; overflow unchanged; new event at the tail.
- With PS2_REPEAT_FILTER_EN: bytes 1C 1C 1C F0 1C 1C -> events {1C,0,0}, {1C,0,1}, {1C,0,0}. Without the macro: five events.
